// File: rtl/apb_resp_pkg.sv
// Shared types, register indices and address-decode helper for the APB register responder.
package apb_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } apb_resp_state_e;

  localparam int REG_ID        = 0;
  localparam int REG_STATUS    = 1;
  localparam int REG_INT_EN    = 2;
  localparam int REG_CTRL_BASE = 3;

  // Misaligned byte offset or a word index past the end of the bank.
  function automatic logic apb_resp_addr_err(input logic [1:0]  byte_off,
                                             input logic [31:0] word_idx,
                                             input logic [31:0] num_regs);
    return (byte_off != 2'b00) || (word_idx >= num_regs);
  endfunction

endpackage

// File: rtl/apb_resp_regbank.sv
// Register storage for the APB responder: RO ID, W1C STATUS, INT_EN, RW control words and irq.
module apb_resp_regbank #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter int                    IDX_W      = 4,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hC0DE_0001
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    wr_en,
  input  logic [IDX_W-1:0]                        wr_idx,
  input  logic [DATA_WIDTH-1:0]                   wr_data,
  input  logic [IDX_W-1:0]                        rd_idx,
  output logic [DATA_WIDTH-1:0]                   rd_data,
  input  logic [DATA_WIDTH-1:0]                   hw_status_set,
  output logic [(NUM_REGS-3)*DATA_WIDTH-1:0]      ctrl_q,
  output logic                                    irq
);
  import apb_resp_pkg::*;

  localparam int NUM_CTRL = NUM_REGS - REG_CTRL_BASE;

  logic [DATA_WIDTH-1:0]          status_q, status_d;
  logic [DATA_WIDTH-1:0]          int_en_q, int_en_d;
  logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_d;
  logic                           irq_q, irq_d;

  // Next-state of every register; a hardware set beats a same-cycle W1C clear.
  always_comb begin
    status_d = (status_q & ~((wr_en && (wr_idx == IDX_W'(REG_STATUS))) ? wr_data : '0))
               | hw_status_set;
    int_en_d = (wr_en && (wr_idx == IDX_W'(REG_INT_EN))) ? wr_data : int_en_q;
    ctrl_d   = ctrl_q;
    for (int i = 0; i < NUM_CTRL; i++) begin
      ctrl_d[i*DATA_WIDTH +: DATA_WIDTH] = (wr_en && (wr_idx == IDX_W'(REG_CTRL_BASE + i)))
                                           ? wr_data : ctrl_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
    irq_d = |(status_q & int_en_q);
  end

  // Read mux taps next-state values so the registered read matches what is held during DONE.
  always_comb begin
    rd_data = '0;
    if (rd_idx == IDX_W'(REG_ID)) begin
      rd_data = ID_VALUE;
    end else if (rd_idx == IDX_W'(REG_STATUS)) begin
      rd_data = status_d;
    end else if (rd_idx == IDX_W'(REG_INT_EN)) begin
      rd_data = int_en_d;
    end else begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        rd_data = rd_data | ((rd_idx == IDX_W'(REG_CTRL_BASE + i))
                             ? ctrl_d[i*DATA_WIDTH +: DATA_WIDTH] : '0);
      end
    end
  end

  // Register storage with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= '0;
      int_en_q <= '0;
      ctrl_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      int_en_q <= int_en_d;
      ctrl_q   <= ctrl_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: rtl/apb_reg_responder.sv
// APB3 completer: setup-phase latching, wait-state counter and registered response
// in front of a small CSR bank.
module apb_reg_responder #(
  parameter int                    ADDR_WIDTH  = 20,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_CYCLES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hC0DE_0001
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [ADDR_WIDTH-1:0]              apb_paddr,
  input  logic                               apb_psel,
  input  logic                               apb_penable,
  input  logic                               apb_pwrite,
  input  logic [DATA_WIDTH-1:0]              apb_pwdata,
  output logic [DATA_WIDTH-1:0]              apb_prdata,
  output logic                               apb_pready,
  output logic                               apb_pslverr,
  input  logic [DATA_WIDTH-1:0]              hw_status_set,
  output logic [(NUM_REGS-3)*DATA_WIDTH-1:0] ctrl_q,
  output logic                               irq
);
  import apb_resp_pkg::*;

  localparam int IDX_W = $clog2(NUM_REGS);

  apb_resp_state_e       state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

  logic                  live_err_s;
  logic [IDX_W-1:0]      sel_idx_s;
  logic                  sel_write_s;
  logic                  sel_err_s;
  logic                  enter_done_s;
  logic                  wr_en_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  assign live_err_s = apb_resp_addr_err(apb_paddr[1:0], 32'(apb_paddr[ADDR_WIDTH-1:2]),
                                        32'(NUM_REGS));

  // With zero wait states DONE is entered on the setup edge, before the latches hold the request.
  always_comb begin
    if (state_q == IDLE) begin
      sel_idx_s   = apb_paddr[IDX_W+1:2];
      sel_write_s = apb_pwrite;
      sel_err_s   = live_err_s;
    end else begin
      sel_idx_s   = idx_q;
      sel_write_s = write_q;
      sel_err_s   = err_q;
    end
  end

  // Transfer FSM next-state, wait counter and response computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    enter_done_s = 1'b0;
    wr_en_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (apb_psel && !apb_penable) begin
          idx_d   = apb_paddr[IDX_W+1:2];
          write_d = apb_pwrite;
          wdata_d = apb_pwdata;
          err_d   = live_err_s;
          if (WAIT_CYCLES == 0) begin
            state_d      = DONE;
            enter_done_s = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!apb_psel || !apb_penable) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d      = DONE;
          cnt_d        = 4'd0;
          enter_done_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        wr_en_s = apb_psel && apb_penable && write_q && !err_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (enter_done_s) begin
      pready_d  = 1'b1;
      pslverr_d = sel_err_s;
      prdata_d  = (!sel_write_s && !sel_err_s) ? rd_data_s : '0;
    end else begin
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
    end
  end

  // FSM state, request latches and registered APB response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign apb_pready  = pready_q;
  assign apb_pslverr = pslverr_q;
  assign apb_prdata  = prdata_q;

  apb_resp_regbank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W),
    .ID_VALUE   (ID_VALUE)
  ) u_regbank (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en_s),
    .wr_idx        (idx_q),
    .wr_data       (wdata_q),
    .rd_idx        (sel_idx_s),
    .rd_data       (rd_data_s),
    .hw_status_set (hw_status_set),
    .ctrl_q        (ctrl_q),
    .irq           (irq)
  );

endmodule

// File: doc/apb_reg_responder.md
# apb_reg_responder

APB3 completer (slave) register block: the responder end of the APB initiator transactor used to configure engines through `.config` read/write vectors. It decodes word-aligned APB reads and writes into a small register bank (an RO ID, a W1C status, an interrupt enable and general RW control registers). It inserts a parameterised number of wait states and flags bad accesses with `pslverr`. It serves as a bench responder model and as a template for engine CSR front ends.

## Interface
Parameters:
- `ADDR_WIDTH`, 20: width of `apb_paddr`.
- `DATA_WIDTH`, 32: width of the APB data path and of every register.
- `NUM_REGS`, 16: register count, minimum 4.
- `WAIT_CYCLES`, 0: number of wait states inserted in every access phase, range 0..15.
- `ID_VALUE`, 32'hC0DE_0001: read value of register 0.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous active-high reset.
- `apb_paddr`  in  ADDR_WIDTH  byte address.
- `apb_psel`  in  1  select.
- `apb_penable`  in  1  access-phase strobe.
- `apb_pwrite`  in  1  1 = write.
- `apb_pwdata`  in  DATA_WIDTH  write data.
- `apb_prdata`  out  DATA_WIDTH  read data; nonzero only while `apb_pready`=1 on a successful read.
- `apb_pready`  out  1  transfer complete.
- `apb_pslverr`  out  1  error; qualified by `apb_pready`.
- `hw_status_set`  in  DATA_WIDTH  per-bit set pulses into STATUS.
- `ctrl_q`  out  (NUM_REGS-3)*DATA_WIDTH  registers 3..NUM_REGS-1 concatenated, register 3 in the LSBs.
- `irq`  out  1  registered OR of (STATUS & INT_EN).

## Operation
Register map, at word index `paddr[ADDR_WIDTH-1:2]`:
- 0 ID: RO, reads `ID_VALUE`. A write is ignored and completes with no error.
- 1 STATUS: W1C. `hw_status_set` bits set the register.
- 2 INT_EN: RW.
- 3..NUM_REGS-1: RW, exposed on `ctrl_q`.

Error rules:
- Error condition: `paddr[1:0]` != 0, or index >= NUM_REGS.
- On error, `apb_pslverr`=1 together with `apb_pready`.
- A write with an error is discarded, and a read with an error returns 0.

FSM states are IDLE, WAIT and DONE.
- IDLE: on `psel`=1 and `penable`=0 (setup phase), latch paddr, pwrite and pwdata and the error decode. Go to WAIT with `cnt`=WAIT_CYCLES, or go straight to DONE when WAIT_CYCLES=0.
- WAIT: decrement `cnt`. Go to DONE at the edge where `cnt`=1.
- DONE: `pready`=1 for exactly one cycle. Any write commits at the edge ending this cycle. Then return to IDLE.
- Abort: in WAIT or DONE, if `psel`=0 or `penable`=0, return to IDLE. Nothing is written and `pready` drops on the next cycle.
- Address, data and direction are taken only from the latched setup values. Changes during the access phase are ignored.

Conflict rule: if a STATUS bit receives an `hw_status_set` and a W1C clear in the same cycle, the set wins and the bit ends at 1.

## Timing
- Reset values:
  - State IDLE.
  - `apb_pready`, `apb_pslverr` and `irq` are 0.
  - `apb_prdata` is 0.
  - STATUS, INT_EN and all ctrl registers are 0.
- Reset asserted mid-transfer forces the reset values on the next edge. The pending write is dropped.
- `apb_pready`, `apb_pslverr` and `apb_prdata` are all registered.
- With setup sampled at edge E0, `pready` is high during cycle E0+1+WAIT_CYCLES. Total transfer length is 2+WAIT_CYCLES cycles, which is the APB minimum when WAIT_CYCLES=0.
- Back-to-back transfers: a setup phase in the cycle right after DONE is accepted. There is no idle-cycle requirement.
- A register write becomes visible on `ctrl_q` one cycle after the DONE edge.
- `irq` lags a STATUS or INT_EN change by 1 cycle.
- A read of STATUS in DONE returns the pre-edge value. It does not include that cycle's `hw_status_set`.

## Structure
- Package `apb_resp_pkg`:
  - `apb_resp_state_e` (IDLE, WAIT, DONE).
  - Index constants `REG_ID`=0, `REG_STATUS`=1, `REG_INT_EN`=2, `REG_CTRL_BASE`=3.
  - Error-decode function `apb_resp_addr_err`.
- Sub-module `apb_resp_regbank`: holds the register storage, the W1C/set logic, the read mux and `irq`.
- The top level holds the APB FSM, the wait counter and the latches.

## Test plan
- WAIT_CYCLES=0: write 0x1234_5678 to 0x0C, then read 0x0C. Required: each transfer takes 2 cycles, the read returns 0x1234_5678, `ctrl_q[31:0]`=0x1234_5678, and `pslverr`=0.
- WAIT_CYCLES=3: read 0x00. Required: `pready` is low for 3 access cycles then high for 1, the read returns 0xC0DE_0001, and a write of 0xFFFF_FFFF to 0x00 leaves ID unchanged with no error.
- Error decode: read 0x02 and write 0x40 (NUM_REGS=16). Required: both give `pslverr`=1 with `pready`, the read returns 0, and no register changes.
- W1C and interrupt:
  - Pulse `hw_status_set`=0x5.
  - Write INT_EN=0x4. Required: `irq`=1.
  - Write STATUS=0x4 with `hw_status_set`=0x4 in the commit cycle. Required: STATUS=0x5 and `irq` stays 1.
  - Write STATUS=0x4 again. Required: STATUS=0x1 and `irq`=0 one cycle later.
- Abort: drop `penable` in the second wait cycle of a write with WAIT_CYCLES=3. Required: no `pready`, the register is unchanged, and a following transfer completes normally.
- Reset mid-write: assert `rst` during WAIT. Required: all outputs return to 0 on the next cycle and the target register stays 0.
